// File: rtl/tour_pkg.sv
// Shared constants, FSM state type and command-building helper for the knight's-tour
// command sequencer and the move decoder.
package tour_pkg;

    // One-hot move masks, named by (dx, dy).
    localparam logic [7:0] MV_XM1_YP2 = 8'h01;
    localparam logic [7:0] MV_XP1_YP2 = 8'h02;
    localparam logic [7:0] MV_XM2_YP1 = 8'h04;
    localparam logic [7:0] MV_XM2_YM1 = 8'h08;
    localparam logic [7:0] MV_XM1_YM2 = 8'h10;
    localparam logic [7:0] MV_XP1_YM2 = 8'h20;
    localparam logic [7:0] MV_XP2_YM1 = 8'h40;
    localparam logic [7:0] MV_XP2_YP1 = 8'h80;

    localparam logic [7:0] HEAD_NORTH = 8'h00;
    localparam logic [7:0] HEAD_WEST  = 8'h3F;
    localparam logic [7:0] HEAD_SOUTH = 8'h7F;
    localparam logic [7:0] HEAD_EAST  = 8'hBF;

    localparam logic [3:0] OP_MOVE    = 4'b0010;
    localparam logic [3:0] OP_FANFARE = 4'b0011;

    localparam logic [7:0] RESP_DONE = 8'hA5;
    localparam logic [7:0] RESP_BUSY = 8'h5A;
    localparam logic [4:0] LAST_MOVE = 5'd23;

    typedef enum logic [2:0] {
        IDLE,
        VERT,
        WAIT_V,
        HORZ,
        WAIT_H
    } state_t;

    // A zero offset takes the positive heading (north / east) with a square count of 0.
    function automatic logic [15:0] leg_cmd(input logic [3:0] op,
                                            input logic signed [2:0] off,
                                            input logic vert);
        logic [7:0] heading;
        logic [2:0] mag;
        if (vert)
            heading = off[2] ? HEAD_SOUTH : HEAD_NORTH;
        else
            heading = off[2] ? HEAD_WEST : HEAD_EAST;
        mag = off[2] ? 3'(-off) : 3'(off);
        return {op, heading, 1'b0, mag};
    endfunction

endpackage

// File: rtl/tour_move_dec.sv
// Combinational knight-move decoder: one-hot move -> signed (x_off, y_off).
// Zero or multi-hot encodings decode to (0,0).
module tour_move_dec
    import tour_pkg::*;
(
    input  logic [7:0]        move,
    output logic signed [2:0] x_off,
    output logic signed [2:0] y_off
);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        x_off = 3'sd0;
        y_off = 3'sd0;
        case (move)
            MV_XM1_YP2: begin x_off = -3'sd1; y_off =  3'sd2; end
            MV_XP1_YP2: begin x_off =  3'sd1; y_off =  3'sd2; end
            MV_XM2_YP1: begin x_off = -3'sd2; y_off =  3'sd1; end
            MV_XM2_YM1: begin x_off = -3'sd2; y_off = -3'sd1; end
            MV_XM1_YM2: begin x_off = -3'sd1; y_off = -3'sd2; end
            MV_XP1_YM2: begin x_off =  3'sd1; y_off = -3'sd2; end
            MV_XP2_YM1: begin x_off =  3'sd2; y_off = -3'sd1; end
            MV_XP2_YP1: begin x_off =  3'sd2; y_off =  3'sd1; end
            default:    begin x_off =  3'sd0; y_off =  3'sd0; end
        endcase
    end

endmodule

// File: rtl/tour_cmd.sv
// Tour command sequencer: passes UART commands through when idle, otherwise replays the
// solver's 24 moves as vertical/horizontal command legs. TOUR_CMD_FANFARE_EN selects the
// fanfare opcode for horizontal legs.
module tour_cmd
    import tour_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    output logic        clr_cmd_rdy_UART,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [7:0]  resp
);

`ifdef TOUR_CMD_FANFARE_EN
    localparam logic [3:0] HORZ_OP = OP_FANFARE;
`else
    localparam logic [3:0] HORZ_OP = OP_MOVE;
`endif

    state_t            state, state_nxt;
    logic signed [2:0] x_off, y_off;
    logic [15:0]       vert_cmd, horz_cmd;
    logic              last_move;

    tour_move_dec u_move_dec (
        .move  (move),
        .x_off (x_off),
        .y_off (y_off)
    );

    assign vert_cmd  = leg_cmd(OP_MOVE, y_off, 1'b1);
    assign horz_cmd  = leg_cmd(HORZ_OP, x_off, 1'b0);
    assign last_move = (mv_indx == LAST_MOVE);

    // NOTE: sequential state uses non-blocking assignments with an async active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mv_indx <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start_tour)
                mv_indx <= '0;
            else if (state == WAIT_H && send_resp && !last_move)
                mv_indx <= mv_indx + 5'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_tour)  state_nxt = VERT;
            VERT:    if (clr_cmd_rdy) state_nxt = WAIT_V;
            WAIT_V:  if (send_resp)   state_nxt = HORZ;
            HORZ:    if (clr_cmd_rdy) state_nxt = WAIT_H;
            WAIT_H:  if (send_resp)   state_nxt = last_move ? IDLE : VERT;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decode from state alone (plus the final send_resp), so reset reaches them at once.
    always_comb begin
        cmd              = cmd_UART;
        cmd_rdy          = 1'b0;
        clr_cmd_rdy_UART = 1'b0;
        resp             = RESP_BUSY;
        case (state)
            IDLE: begin
                cmd_rdy          = cmd_rdy_UART;
                clr_cmd_rdy_UART = clr_cmd_rdy;
                resp             = RESP_DONE;
            end
            VERT: begin
                cmd     = vert_cmd;
                cmd_rdy = 1'b1;
            end
            WAIT_V: cmd = vert_cmd;
            HORZ: begin
                cmd     = horz_cmd;
                cmd_rdy = 1'b1;
            end
            WAIT_H: begin
                cmd = horz_cmd;
                if (send_resp && last_move)
                    resp = RESP_DONE;
            end
            default: begin
                cmd  = cmd_UART;
                resp = RESP_DONE;
            end
        endcase
    end

endmodule

// File: tb/tb_tour_cmd.sv
// Bench for tour_cmd: acts as solver and command processor with random handshake delays;
// expected commands are queued at tour start and popped by a monitor at each accept.
module tb_tour_cmd;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_tour = 1'b0;
    logic [7:0]  move;
    logic [4:0]  mv_indx;
    logic [15:0] cmd_UART = 16'h1234;
    logic        cmd_rdy_UART = 1'b0;
    logic        clr_cmd_rdy_UART;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic        send_resp = 1'b0;
    logic [7:0]  resp;

`ifdef TOUR_CMD_FANFARE_EN
    localparam logic [3:0] EXP_H_OP = 4'b0011;
`else
    localparam logic [3:0] EXP_H_OP = 4'b0010;
`endif

    typedef struct {
        logic [15:0] cmd;
        bit          chk_idx;
        logic [4:0]  idx;
        logic        uclr;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] tour_moves[32];
    int         dx_tab[8] = '{-1, 1, -2, -2, -1, 1, 2, 2};
    int         dy_tab[8] = '{ 2, 2,  1, -1, -2, -2, -1, 1};
    int         checks = 0;
    int         errors = 0;

    assign move = tour_moves[mv_indx];

    tour_cmd dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_tour       (start_tour),
        .move             (move),
        .mv_indx          (mv_indx),
        .cmd_UART         (cmd_UART),
        .cmd_rdy_UART     (cmd_rdy_UART),
        .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
        .cmd              (cmd),
        .cmd_rdy          (cmd_rdy),
        .clr_cmd_rdy      (clr_cmd_rdy),
        .send_resp        (send_resp),
        .resp             (resp)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Reference: the move table gives the offsets, headings follow the sign of the offset.
    function automatic void ref_move(input logic [7:0] m, output int dx, output int dy);
        dx = 0;
        dy = 0;
        for (int b = 0; b < 8; b++)
            if (m == (8'h01 << b)) begin
                dx = dx_tab[b];
                dy = dy_tab[b];
            end
    endfunction

    function automatic logic [15:0] ref_leg(input logic [3:0] op, input int off, input bit vert);
        logic [7:0] h;
        int         mag;
        mag = (off < 0) ? -off : off;
        if (vert) h = (off < 0) ? 8'h7F : 8'h00;
        else      h = (off < 0) ? 8'h3F : 8'hBF;
        return {op, h, 4'(mag)};
    endfunction

    task automatic push_tour();
        int dx, dy;
        for (int i = 0; i < 24; i++) begin
            ref_move(tour_moves[i], dx, dy);
            sb.push_back('{ref_leg(4'b0010, dy, 1'b1), 1'b1, 5'(i), 1'b0});
            sb.push_back('{ref_leg(EXP_H_OP, dx, 1'b0), 1'b1, 5'(i), 1'b0});
        end
    endtask

    task automatic fill_moves();
        for (int i = 0; i < 32; i++)
            tour_moves[i] = 8'h01 << $urandom_range(0, 7);
    endtask

    // Monitor: every accepted command is compared against the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && cmd_rdy && clr_cmd_rdy) begin
            if (sb.size() == 0) begin
                fail_now("sb_underflow");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("cmd", 32'(cmd), 32'(e.cmd));
                check("clr_cmd_rdy_UART", 32'(clr_cmd_rdy_UART), 32'(e.uclr));
                if (e.chk_idx)
                    check("mv_indx", 32'(mv_indx), 32'(e.idx));
            end
        end
    end

    // Command-processor model for one leg; stray acks are thrown in to show they are ignored.
    task automatic serve_leg(input logic [7:0] exp_resp, input bit stop_before_resp);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_rdy) begin
            fail_now("cmd_rdy_timeout");
            return;
        end
        check("busy_resp", 32'(resp), 32'h5A);
        if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1 send_resp = 1'b1;
            @(posedge clk); #1 send_resp = 1'b0;
        end
        repeat ($urandom_range(0, 3)) @(negedge clk);
        @(posedge clk); #1 clr_cmd_rdy = 1'b1;
        @(posedge clk); #1 clr_cmd_rdy = 1'b0;
        @(negedge clk);
        check("wait_cmd_rdy", 32'(cmd_rdy), 32'h0);
        check("wait_clr_uart", 32'(clr_cmd_rdy_UART), 32'h0);
        if (stop_before_resp) return;
        if ($urandom_range(0, 2) == 0) begin
            @(posedge clk); #1 clr_cmd_rdy = 1'b1;
            @(posedge clk); #1 clr_cmd_rdy = 1'b0;
        end
        repeat ($urandom_range(0, 3)) @(negedge clk);
        @(posedge clk); #1 send_resp = 1'b1;
        @(negedge clk);
        check("send_resp_resp", 32'(resp), 32'(exp_resp));
        @(posedge clk); #1 send_resp = 1'b0;
    endtask

    task automatic passthrough(input logic [15:0] value);
        cmd_UART     = value;
        cmd_rdy_UART = 1'b1;
        sb.push_back('{value, 1'b0, 5'd0, 1'b1});
        @(negedge clk);
        check("pt_cmd", 32'(cmd), 32'(value));
        check("pt_cmd_rdy", 32'(cmd_rdy), 32'h1);
        check("pt_resp", 32'(resp), 32'hA5);
        check("pt_clr_idle", 32'(clr_cmd_rdy_UART), 32'h0);
        @(posedge clk); #1 clr_cmd_rdy = 1'b1;
        @(posedge clk); #1 clr_cmd_rdy = 1'b0;
        cmd_rdy_UART = 1'b0;
        @(negedge clk);
        check("pt_cmd_rdy_low", 32'(cmd_rdy), 32'h0);
    endtask

    task automatic begin_tour();
        cmd_rdy_UART = 1'b0;
        push_tour();
        @(posedge clk); #1 start_tour = 1'b1;
        @(posedge clk); #1 start_tour = 1'b0;
        cmd_UART     = 16'($urandom);
        cmd_rdy_UART = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) tour_moves[i] = 8'h00;

        // Reset state, with outputs already in pass-through while reset is held.
        repeat (2) @(posedge clk);
        #1;
        check("rst_mv_indx", 32'(mv_indx), 32'h0);
        check("rst_resp", 32'(resp), 32'hA5);
        check("rst_cmd", 32'(cmd), 32'h1234);
        check("rst_cmd_rdy", 32'(cmd_rdy), 32'h0);
        rst_n = 1'b1;

        passthrough(16'h2004);

        // Tour 1: directed first moves (incl. zero and multi-hot), then random one-hot.
        fill_moves();
        tour_moves[0] = 8'h01;
        tour_moves[1] = 8'h40;
        tour_moves[2] = 8'h00;
        tour_moves[3] = 8'h81;
        begin_tour();
        for (int i = 0; i < 24; i++) begin
            if (i == 5) begin
                @(posedge clk); #1 start_tour = 1'b1;
                @(posedge clk); #1 start_tour = 1'b0;
            end
            serve_leg(8'h5A, 1'b0);
            serve_leg((i == 23) ? 8'hA5 : 8'h5A, 1'b0);
        end
        @(negedge clk);
        check("end_idle_cmd", 32'(cmd), 32'(cmd_UART));
        check("end_idle_rdy", 32'(cmd_rdy), 32'h1);
        check("end_idle_resp", 32'(resp), 32'hA5);
        check("end_sb_empty", 32'(sb.size()), 32'h0);
        cmd_rdy_UART = 1'b0;
        passthrough(16'h2BF2);

        // Tour 2: reset asserted while waiting in WAIT_H.
        fill_moves();
        begin_tour();
        for (int i = 0; i < 3; i++) begin
            serve_leg(8'h5A, 1'b0);
            serve_leg(8'h5A, 1'b0);
        end
        serve_leg(8'h5A, 1'b0);
        serve_leg(8'h5A, 1'b1);
        check("pre_rst_mv_indx", 32'(mv_indx), 32'h3);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_mv_indx", 32'(mv_indx), 32'h0);
        check("midrst_resp", 32'(resp), 32'hA5);
        check("midrst_cmd", 32'(cmd), 32'(cmd_UART));
        check("midrst_cmd_rdy", 32'(cmd_rdy), 32'h1);
        sb.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        cmd_rdy_UART = 1'b0;
        passthrough(16'h27F1);
        check("final_mv_indx", 32'(mv_indx), 32'h0);
        check("final_sb_empty", 32'(sb.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tour_cmd.md
TOUR_CMD -- requirements
Module: tour_cmd

Interface
REQ-001 clk  input  1  system clock; all state on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 start_tour  input  1  one-cycle pulse from the tour solver when a solution is complete.
REQ-004 move  input  8  one-hot knight move returned by the solver for mv_indx.
REQ-005 mv_indx  output  5  registered index of the move being read from the solver.
REQ-006 cmd_UART  input  16  command from the UART/BLE path.
REQ-007 cmd_rdy_UART  input  1  cmd_UART valid.
REQ-008 clr_cmd_rdy_UART  output  1  acknowledge to the UART path.
REQ-009 cmd  output  16  command to the command processor.
REQ-010 cmd_rdy  output  1  cmd valid.
REQ-011 clr_cmd_rdy  input  1  acknowledge from the command processor.
REQ-012 send_resp  input  1  pulse from the command processor when a command has completed.
REQ-013 resp  output  8  response byte.

Function
REQ-014 Move decode SHALL be:
- bit0 (-1,+2), bit1 (+1,+2), bit2 (-2,+1), bit3 (-2,-1)
- bit4 (-1,-2), bit5 (+1,-2), bit6 (+2,-1), bit7 (+2,+1)
- zero or multi-hot input SHALL decode to (0,0).
REQ-015 Command format SHALL be:
- cmd[15:12] opcode; cmd[11:4] heading; cmd[3:0] square count = |offset|.
- Headings: north 8'h00 (+y), west 8'h3F (-x), south 8'h7F (-y), east 8'hBF (+x).
REQ-016 Each move SHALL be issued as two legs: first the vertical leg, opcode 4'b0010; then the horizontal leg, opcode per REQ-026.
REQ-017 FSM states SHALL be IDLE, VERT, WAIT_V, HORZ and WAIT_H.
REQ-018 In IDLE the block SHALL be a pass-through:
- cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, clr_cmd_rdy_UART=clr_cmd_rdy.
- resp=8'hA5.
REQ-019 IDLE -> VERT on start_tour; mv_indx SHALL be cleared to 0 on the same edge.
REQ-020 In VERT, cmd SHALL be the vertical leg for move and cmd_rdy SHALL be 1. On clr_cmd_rdy -> WAIT_V.
REQ-021 In WAIT_V, cmd_rdy SHALL be 0. On send_resp -> HORZ.
REQ-022 In HORZ, cmd SHALL be the horizontal leg and cmd_rdy SHALL be 1. On clr_cmd_rdy -> WAIT_H.
REQ-023 In WAIT_H, on send_resp:
- if mv_indx==23 -> IDLE;
- else mv_indx increments and -> VERT.
REQ-024 Outside IDLE:
- cmd_UART and cmd_rdy_UART SHALL be ignored and clr_cmd_rdy_UART SHALL be 0;
- start_tour SHALL be ignored;
- resp SHALL be 8'h5A, except during the WAIT_H cycle in which send_resp arrives with mv_indx==23, when resp SHALL be 8'hA5.
REQ-025 clr_cmd_rdy or send_resp arriving in a state that does not expect it SHALL be ignored.

Configuration
REQ-026 The macro TOUR_CMD_FANFARE_EN SHALL select the horizontal-leg opcode:
- defined: 4'b0011 (move with fanfare);
- undefined: 4'b0010. All else unchanged.

Reset
REQ-027 On rst_n low: state=IDLE, mv_indx=0.
REQ-028 Outputs SHALL follow the IDLE pass-through values immediately on reset, including when reset is asserted mid-tour.

Structure
REQ-029 Package tour_pkg SHALL hold:
- move-bit localparams;
- heading and opcode constants;
- the FSM state typedef.
REQ-030 Sub-module tour_move_dec SHALL be combinational, move[7:0] -> signed 3-bit x_off and y_off, and is reusable by the solver.

Verification
REQ-031 IDLE pass-through: cmd_UART=16'h2004, cmd_rdy_UART=1, clr_cmd_rdy pulse -> cmd=16'h2004, cmd_rdy=1, clr_cmd_rdy_UART pulses, resp=8'hA5.
REQ-032 First move: start_tour, move=8'h01 -> cmd=16'h2002 (north 2) with cmd_rdy; after clr_cmd_rdy and send_resp -> cmd=16'h23F1 (west 1; 16'h33F1 with TOUR_CMD_FANFARE_EN).
REQ-033 Southward and east legs: move=8'h40 -> vertical 16'h27F1, horizontal 16'h2BF2.
REQ-034 Full tour of 24 moves with random handshake delays -> 48 commands in order; mv_indx steps 0..23; resp=8'h5A until the final send_resp, which gives 8'hA5; then return to IDLE.
REQ-035 Robustness:
- start_tour pulse mid-tour -> no effect;
- rst_n asserted in WAIT_H -> IDLE, mv_indx=0, pass-through resumes;
- move=8'h00 -> squares field 0.
